// File: rtl/id_decode_queue.sv
// Decode/issue buffer between fetch and dispatch: per-lane decode into
// pc_set_t records, a circular queue, and in-order grouped issue with
// intra-group pairing rules.

package id_decode_queue_pkg;
   // Decoded instruction record carried from decode to dispatch
   typedef struct packed {
      logic        o_valid;
      logic        o_inst_lawful;
      logic [31:0] pc;
      logic [31:0] ir;
      logic [31:0] imm;
      logic [3:0]  br_type;
      logic [1:0]  inst_type;   // [1] load/store, [0] ALU
      logic        rf_we;
      logic [4:0]  rf_rd;
      logic [4:0]  rf_raddr1;
      logic [4:0]  rf_raddr2;
   } pc_set_t;
endpackage

// Per-lane combinational decoder for the LA32 subset used by the pipeline
module id_decode_lane
   import id_decode_queue_pkg::*;
(
   input  logic        data_valid,
   input  logic [31:0] ir,
   input  logic [31:0] pc,
   output pc_set_t     rec
);
   logic [5:0]  op6;
   logic [6:0]  op7;
   logic [9:0]  op10;
   logic [16:0] op17;
   logic [4:0]  rd, rj, rk;
   logic [31:0] si12, ui12, si20, offs16, offs26;
   logic        we_raw;
   logic [4:0]  wr_reg;

   assign op6    = ir[31:26];
   assign op7    = ir[31:25];
   assign op10   = ir[31:22];
   assign op17   = ir[31:15];
   assign rd     = ir[4:0];
   assign rj     = ir[9:5];
   assign rk     = ir[14:10];
   assign si12   = {{20{ir[21]}}, ir[21:10]};
   assign ui12   = {20'd0, ir[21:10]};
   assign si20   = {ir[24:5], 12'd0};
   assign offs16 = {{14{ir[25]}}, ir[25:10], 2'b00};
   assign offs26 = {{4{ir[9]}}, ir[9:0], ir[25:10], 2'b00};

   // Field extraction; unrecognised encodings stay unlawful with no side effects
   always_comb begin
      rec    = '0;
      we_raw = 1'b0;
      wr_reg = rd;
      rec.pc = pc;
      rec.ir = ir;
      if (op17 inside {17'h00020, 17'h00022, 17'h00024, 17'h00025, 17'h00028,
                       17'h00029, 17'h0002A, 17'h0002B, 17'h00038}) begin
         rec.o_inst_lawful = 1'b1;
         we_raw            = 1'b1;
         rec.rf_raddr1     = rj;
         rec.rf_raddr2     = rk;
         rec.inst_type     = 2'b01;
      end else if (op10 inside {10'h008, 10'h009, 10'h00A}) begin
         rec.o_inst_lawful = 1'b1;
         we_raw            = 1'b1;
         rec.rf_raddr1     = rj;
         rec.inst_type     = 2'b01;
         rec.imm           = si12;
      end else if (op10 inside {10'h00D, 10'h00E, 10'h00F}) begin
         rec.o_inst_lawful = 1'b1;
         we_raw            = 1'b1;
         rec.rf_raddr1     = rj;
         rec.inst_type     = 2'b01;
         rec.imm           = ui12;
      end else if (op10 inside {10'h0A0, 10'h0A1, 10'h0A2, 10'h0A8, 10'h0A9}) begin
         rec.o_inst_lawful = 1'b1;
         we_raw            = 1'b1;
         rec.rf_raddr1     = rj;
         rec.inst_type     = 2'b10;
         rec.imm           = si12;
      end else if (op10 inside {10'h0A4, 10'h0A5, 10'h0A6}) begin
         rec.o_inst_lawful = 1'b1;
         rec.rf_raddr1     = rj;
         rec.rf_raddr2     = rd;
         rec.inst_type     = 2'b10;
         rec.imm           = si12;
      end else if (op7 == 7'b0001010) begin
         rec.o_inst_lawful = 1'b1;
         we_raw            = 1'b1;
         rec.inst_type     = 2'b01;
         rec.imm           = si20;
      end else begin
         case (op6)
            6'h13: begin
               rec.o_inst_lawful = 1'b1;
               rec.br_type       = 4'd1;
               we_raw            = 1'b1;
               rec.rf_raddr1     = rj;
               rec.imm           = offs16;
            end
            6'h14: begin
               rec.o_inst_lawful = 1'b1;
               rec.br_type       = 4'd2;
               rec.imm           = offs26;
            end
            6'h15: begin
               rec.o_inst_lawful = 1'b1;
               rec.br_type       = 4'd3;
               we_raw            = 1'b1;
               wr_reg            = 5'd1;
               rec.imm           = offs26;
            end
            6'h16, 6'h17, 6'h18, 6'h19, 6'h1A, 6'h1B: begin
               rec.o_inst_lawful = 1'b1;
               rec.br_type       = 4'(op6 - 6'h12);
               rec.rf_raddr1     = rj;
               rec.rf_raddr2     = rd;
               rec.imm           = offs16;
            end
            default: ;
         endcase
      end
      // Writes to r0 are dropped, so rf_rd is nonzero whenever rf_we is set
      rec.rf_we   = we_raw && (wr_reg != 5'd0);
      rec.rf_rd   = rec.rf_we ? wr_reg : 5'd0;
      rec.o_valid = data_valid && rec.o_inst_lawful;
   end
endmodule

module id_decode_queue
   import id_decode_queue_pkg::*;
#(
   parameter int unsigned FETCH_WIDTH = 2,
   parameter int unsigned ISSUE_WIDTH = 2,
   parameter int unsigned DEPTH       = 8
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic [FETCH_WIDTH-1:0]        fetch_valid,
   input  logic [32*FETCH_WIDTH-1:0]     fetch_ir,
   input  logic [32*FETCH_WIDTH-1:0]     fetch_pc,
   output logic                          fetch_ready,
   output pc_set_t [ISSUE_WIDTH-1:0]     issue_pkt,
   output logic [ISSUE_WIDTH-1:0]        issue_valid,
   input  logic                          issue_ready,
   output logic [$clog2(DEPTH):0]        occupancy
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;

   pc_set_t              dec_rec [FETCH_WIDTH];
   pc_set_t              mem     [DEPTH];
   logic [PTR_W-1:0]     head, tail;
   logic [OCC_W-1:0]     enq_cnt, deq_cnt, issue_cnt, hold_cnt;
   logic                 hold_act, enq_en;
   logic [ISSUE_WIDTH-1:0] lane_ok;

   // True when b may not share an issue group behind the older record a
   function automatic logic pair_blocks(input pc_set_t a, input pc_set_t b);
      return (a.br_type != 4'd0) || !a.o_inst_lawful || !b.o_inst_lawful ||
             (a.inst_type[1] && b.inst_type[1]) ||
             (a.rf_we && ((a.rf_rd == b.rf_raddr1) || (a.rf_rd == b.rf_raddr2))) ||
             (a.rf_we && b.rf_we && (a.rf_rd == b.rf_rd));
   endfunction

   for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_dec
      id_decode_lane u_dec (
         .data_valid (1'b1),
         .ir         (fetch_ir[32*g +: 32]),
         .pc         (fetch_pc[32*g +: 32]),
         .rec        (dec_rec[g])
      );
   end

   // Room for a whole fetch group, from registered occupancy only
   assign fetch_ready = (OCC_W'(DEPTH) - occupancy) >= OCC_W'(FETCH_WIDTH);
   assign enq_en      = fetch_ready && !flush;

   // Enqueue count from the fetch valid mask
   always_comb begin
      enq_cnt = '0;
      if (enq_en) begin
         for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            enq_cnt = enq_cnt + OCC_W'(fetch_valid[i]);
         end
      end
   end

   // Issue group selection from the oldest entries; a stalled group never grows
   always_comb begin
      lane_ok     = '0;
      issue_valid = '0;
      issue_cnt   = '0;
      for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
         issue_pkt[k] = mem[head + PTR_W'(k)];
      end
      for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
         lane_ok[k] = (occupancy > OCC_W'(k)) && !flush &&
                      (!hold_act || (OCC_W'(k) < hold_cnt));
         for (int unsigned j = 0; j < k; j++) begin
            if (pair_blocks(issue_pkt[j], issue_pkt[k])) lane_ok[k] = 1'b0;
         end
      end
      issue_valid[0] = lane_ok[0];
      for (int unsigned k = 1; k < ISSUE_WIDTH; k++) begin
         issue_valid[k] = issue_valid[k-1] && lane_ok[k];
      end
      for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
         issue_cnt = issue_cnt + OCC_W'(issue_valid[k]);
      end
      deq_cnt = issue_ready ? issue_cnt : '0;
   end

   // Queue storage write; contents are not reset
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
         if (enq_en && fetch_valid[i]) mem[tail + PTR_W'(i)] <= dec_rec[i];
      end
   end

   // Pointers, occupancy and the stalled-group hold state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head      <= '0;
         tail      <= '0;
         occupancy <= '0;
         hold_act  <= 1'b0;
         hold_cnt  <= '0;
      end else if (flush) begin
         head      <= '0;
         tail      <= '0;
         occupancy <= '0;
         hold_act  <= 1'b0;
         hold_cnt  <= '0;
      end else begin
         head      <= head + PTR_W'(deq_cnt);
         tail      <= tail + PTR_W'(enq_cnt);
         occupancy <= occupancy + enq_cnt - deq_cnt;
         hold_act  <= (issue_cnt != '0) && !issue_ready;
         hold_cnt  <= issue_cnt;
      end
   end
endmodule

// File: doc/id_decode_queue.md
Name: id_decode_queue

Overview:
- Parametrised decode/issue buffer between fetch and dispatch in the dual-issue LoongArch pipeline.
- Each cycle, accepts up to FETCH_WIDTH fetched instructions and decodes each lane with the existing per-lane combinational decoder into a PC_set record.
- Stores the decoded records in a circular queue.
- Each cycle, issues up to ISSUE_WIDTH records in program order, applying intra-group pairing rules.

Parameters:
- FETCH_WIDTH, 2, instructions accepted per cycle (1..4).
- ISSUE_WIDTH, 2, maximum records issued per cycle (1..4, at most DEPTH).
- DEPTH, 8, queue entries; power of two, at least 2*FETCH_WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  discard all queued and incoming instructions.
- fetch_valid  in  FETCH_WIDTH  per-lane valid; contiguous from lane 0.
- fetch_ir  in  32*FETCH_WIDTH  instruction words; lane i at [32i+31:32i].
- fetch_pc  in  32*FETCH_WIDTH  PCs, same packing as fetch_ir.
- fetch_ready  out  1  queue can accept a full fetch group this cycle.
- issue_pkt  out  PC_set x ISSUE_WIDTH  decoded records; lane 0 is the oldest.
- issue_valid  out  ISSUE_WIDTH  per-lane valid; contiguous from lane 0.
- issue_ready  in  1  downstream takes every valid issue lane this cycle.
- occupancy  out  clog2(DEPTH)+1  current entry count.

Behaviour:
- Reset (async assert):
  - head, tail and occupancy go to 0.
  - issue_valid goes to 0.
  - fetch_ready goes to 1.
  - Stored entries are don't-care.
- fetch_ready = (DEPTH - occupancy) >= FETCH_WIDTH. It uses registered occupancy only; there is no combinational path from issue_ready.
- Enqueue:
  - Happens when fetch_ready && !flush. Every lane i with fetch_valid[i] is decoded, with decoder data_valid = 1.
  - Each valid lane is written at tail+i (mod DEPTH). tail advances by popcount(fetch_valid).
  - Writes with fetch_ready = 0 are ignored, and fetch must hold its inputs.
- Latency: an entry written at edge t can appear on issue_pkt from cycle t+1. There is no fetch-to-issue bypass.
- Issue lane selection (combinational from queue state):
  - Lane 0 is valid iff occupancy >= 1 && !flush.
  - Lane k>0 is valid iff all of the following hold:
    - lane k-1 is valid;
    - occupancy > k;
    - none of the blocking rules below applies.
- Rules that block lane k from issuing:
  - Any earlier lane j<k in the group has br_type != 0, so a branch ends the group.
  - RAW hazard: an earlier lane j has rf_we = 1, and its rf_rd (which is nonzero) equals lane k's rf_raddr1 or rf_raddr2.
  - WAW hazard: an earlier lane has rf_we = 1 with the same rf_rd as lane k, and lane k also has rf_we = 1.
  - Memory: an earlier lane and lane k both have inst_type[1] = 1, so at most one load/store per group.
  - Lane k has o_inst_lawful = 0. An illegal instruction issues only alone in lane 0, carrying o_valid = 0 for the exception path.
- Dequeue:
  - When issue_ready, head advances by popcount(issue_valid).
  - issue_valid and issue_pkt must stay stable while !issue_ready.
- occupancy_next = occupancy + enq_count - deq_count. Simultaneous enqueue and dequeue are legal; a full queue can dequeue and refill in the same cycle.
- Pointer arithmetic: head and tail are clog2(DEPTH) bits and wrap modulo DEPTH. Full vs empty is resolved by occupancy, not by pointer compare.
- Flush:
  - issue_valid is 0 in the flush cycle, and no enqueue or dequeue takes place.
  - At the next edge, head = tail = 0 and occupancy = 0. Contents are not cleared.
- Reset mid-operation: all in-flight entries are lost, and behaviour is identical to power-on reset.

Test Plan:
- Dependent pair:
  - Stimulus: after reset, enqueue add.w r3,r1,r2 (0x00100823) and addi.w r4,r3,1 (0x02800464).
  - Response: one cycle later issue_valid=2'b01 with the add. The next cycle issue_valid=2'b01 with the addi (RAW).
- Independent pair:
  - Stimulus: enqueue add.w r3,r1,r2 (0x00100823) and addi.w r5,r1,1 (0x02800425).
  - Response: issue_valid=2'b11 in one cycle; occupancy goes 2 -> 0.
- Two loads:
  - Stimulus: enqueue ld.w r5,r1,0 (0x28800025) and ld.w r6,r1,4 (0x28801026).
  - Response: they issue in separate cycles.
- Branch then ALU:
  - Stimulus: enqueue beq (0x58000000) followed by the ALU op.
  - Response: beq issues alone in lane 0.
- Fill with backpressure:
  - Stimulus: hold issue_ready=0 and enqueue 4 full groups.
  - Response: occupancy=8 and fetch_ready=0. A 5th group is ignored, and head/tail wrap correctly when draining.
- Flush and reset:
  - Stimulus: with occupancy=6, assert flush for one cycle while fetch_valid=2'b11.
  - Response: issue_valid=0 in that cycle and occupancy=0 after it.
  - Stimulus: assert rst asynchronously mid-cycle.
  - Response: outputs go to their reset values immediately.
